// File: rtl/chs_actuator_ctrl.sv
// Ramps applied power one level at a time toward a {power, mode} request and drives heater/cooler PWM.
// Requests accepted in IDLE only; define CHS_RETARGET_EN to also accept retargets during RAMP.
module chs_actuator_ctrl #(
  parameter int RAMP_DIV  = 4,
  parameter int DEAD_TIME = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       chs_valid,
  output logic       chs_ready,
  input  logic [3:0] chs_power,
  input  logic       chs_mode,
  output logic [3:0] act_power,
  output logic       act_mode,
  output logic       heat_pwm,
  output logic       cool_pwm,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RAMP, DRAIN, DEAD} state_e;

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_TIME - 1);
  localparam logic [3:0] PWR_MAX   = 4'd8;

  state_e     state_q, state_d;
  logic [3:0] act_power_q, act_power_d;
  logic [3:0] tgt_power_q, tgt_power_d;
  logic       act_mode_q, act_mode_d;
  logic       tgt_mode_q, tgt_mode_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] slot_q;
  logic       accept;
  logic       slot_on;
  logic [3:0] req_power;
  logic [3:0] ramp_tgt;

`ifdef CHS_RETARGET_EN
  assign chs_ready = (state_q == IDLE) || (state_q == RAMP);
`else
  assign chs_ready = (state_q == IDLE);
`endif

  assign accept    = chs_valid && chs_ready;
  assign req_power = (chs_power > PWR_MAX) ? PWR_MAX : chs_power;

  always_comb begin
    state_d     = state_q;
    act_power_d = act_power_q;
    act_mode_d  = act_mode_q;
    tgt_power_d = tgt_power_q;
    tgt_mode_d  = tgt_mode_q;
    cnt_d       = cnt_q;
    ramp_tgt    = tgt_power_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_power_d = req_power;
          tgt_mode_d  = chs_mode;
          cnt_d       = '0;
          if (chs_mode != act_mode_q) begin
            state_d = (act_power_q != 4'd0) ? DRAIN : DEAD;
          end else if (req_power != act_power_q) begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
`ifdef CHS_RETARGET_EN
        // A retarget keeps the step counter running so the ramp cadence is not disturbed.
        if (accept) begin
          tgt_power_d = req_power;
          tgt_mode_d  = chs_mode;
          ramp_tgt    = req_power;
        end
        if (accept && (chs_mode != act_mode_q)) begin
          state_d = (act_power_q != 4'd0) ? DRAIN : DEAD;
          cnt_d   = '0;
        end else
`endif
        if (ramp_tgt == act_power_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= RAMP_LAST) begin
          act_power_d = (ramp_tgt > act_power_q) ? act_power_q + 4'd1 : act_power_q - 4'd1;
          cnt_d       = '0;
          if (act_power_d == ramp_tgt) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (act_power_q == 4'd0) begin
          state_d = DEAD;
          cnt_d   = '0;
        end else if (cnt_q >= RAMP_LAST) begin
          act_power_d = act_power_q - 4'd1;
          cnt_d       = '0;
          if (act_power_q == 4'd1) state_d = DEAD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DEAD: begin
        if (cnt_q >= DEAD_LAST) begin
          act_mode_d = tgt_mode_q;
          cnt_d      = '0;
          state_d    = (tgt_power_q != 4'd0) ? RAMP : IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_power_q <= '0;
      act_mode_q  <= 1'b0;
      tgt_power_q <= '0;
      tgt_mode_q  <= 1'b0;
      cnt_q       <= '0;
      slot_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_power_q <= act_power_d;
      act_mode_q  <= act_mode_d;
      tgt_power_q <= tgt_power_d;
      tgt_mode_q  <= tgt_mode_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_q + 3'd1;
    end
  end

  // PWM is decoded from registers only; the dead-time gate keeps both actuators off across a mode flip.
  assign slot_on   = ({1'b0, slot_q} < act_power_q) && (state_q != DEAD);
  assign heat_pwm  = act_mode_q & slot_on;
  assign cool_pwm  = ~act_mode_q & slot_on;
  assign act_power = act_power_q;
  assign act_mode  = act_mode_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/chs_actuator_ctrl.md
Name: chs_actuator_ctrl

Overview:
- Downstream consumer of the mode/power decoder (8-bit temperature config → 4-bit power level + heat/cool mode).
- Takes {chs_power, chs_mode} requests over a valid/ready handshake.
- Ramps the applied power one level at a time toward the target. A direction change first drains power to 0, then inserts a dead-time in which both actuators are off.
- Drives heater and cooler PWM outputs: 8-slot period, duty = applied power / 8.

Parameters:
- RAMP_DIV, 4, clock cycles per ±1 power step; legal range 1..255.
- DEAD_TIME, 8, cycles with both PWM outputs off before the mode flips; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- chs_valid  input  1  request valid
- chs_ready  output  1  block can accept a request
- chs_power  input  4  requested power level (0..8 nominal)
- chs_mode  input  1  requested mode; 1 = heat, 0 = cool
- act_power  output  4  currently applied power level
- act_mode  output  1  currently applied mode
- heat_pwm  output  1  heater drive
- cool_pwm  output  1  cooler drive
- busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low, and has priority over all other inputs.
- Reset values: state=IDLE, act_power=0, act_mode=0, tgt_power=0, tgt_mode=0, slot counter=0, step/dead counter=0, heat_pwm=0, cool_pwm=0, busy=0, chs_ready=1.
- Handshake:
  - A transfer occurs on a rising edge where chs_valid && chs_ready.
  - chs_ready is high only in IDLE.
  - chs_valid/data may be held while ready is low; nothing is latched until a transfer.
- Input clamp: on accept, tgt_power = (chs_power > 8) ? 8 : chs_power; tgt_mode = chs_mode.
- State IDLE, on accept:
  - mode differs and act_power > 0 → DRAIN
  - mode differs and act_power = 0 → DEAD
  - mode same and tgt_power != act_power → RAMP
  - otherwise stay in IDLE
  - The step/dead counter clears on every state entry.
- State RAMP:
  - The counter increments each cycle.
  - When it reaches RAMP_DIV-1, act_power moves ±1 toward tgt_power and the counter clears.
  - Counting the accept edge as edge 0, steps land on edges RAMP_DIV, 2·RAMP_DIV, …
  - State returns to IDLE on the same edge as the final step.
- State DRAIN: same stepping as RAMP, but toward 0. Goes to DEAD on the edge where act_power reaches 0.
- State DEAD:
  - heat_pwm = cool_pwm = 0 throughout.
  - After DEAD_TIME cycles, act_mode ← tgt_mode on the exiting edge.
  - Next state is RAMP if tgt_power > 0, else IDLE.
- PWM:
  - 3-bit slot counter, free-running, wraps 7→0.
  - heat_pwm = act_mode & (slot < act_power) & (state != DEAD).
  - cool_pwm = ~act_mode & (slot < act_power) & (state != DEAD).
  - act_power = 8 gives a constant high; 0 gives a constant low.
  - Both outputs are decoded only from registers, so there is no combinational path from any input.
  - heat_pwm and cool_pwm are never high simultaneously.
- Arithmetic: act_power stays within 0..8 in all states, with no wrap. Counters are 8-bit and saturate at their parameter value.
- Reset mid-operation (any state): all reset values apply on the next edge. The pending target is discarded.

Optional Feature:
- Macro: CHS_RETARGET_EN.
- Defined:
  - chs_ready is also high in RAMP.
  - A same-mode accept in RAMP updates tgt_power and does not clear the step counter.
  - If the new tgt_power equals act_power, state → IDLE on that edge.
  - A different-mode accept in RAMP → DRAIN, or → DEAD if act_power = 0.
  - DRAIN and DEAD never accept.
- Undefined: chs_ready is high in IDLE only, as above.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with chs_valid=1 → act_power=0, act_mode=0, both PWM outputs 0, busy=0, chs_ready=1; no request is latched.
- Ramp up (RAMP_DIV=4): from reset, accept power=3, mode=0 at edge 0 → act_power=1/2/3 at edges 4/8/12, busy drops after edge 12, cool_pwm high in slots 0..2 of every 8-slot period, heat_pwm stays 0.
- Mode switch (DEAD_TIME=8): at power 3 cool, accept power=2, mode=1 → act_power reaches 0 by edge 12, both PWM outputs 0 for 8 cycles, act_mode=1 at edge 20, act_power=2 at edge 28.
- Clamp: accept chs_power=4'd12, mode=1 → tgt_power=8, act_power ends at 8, heat_pwm constantly high.
- Backpressure: hold valid with a new request during RAMP → not accepted (macro off) until IDLE. With CHS_RETARGET_EN, it is accepted mid-ramp and act_power stops at the new target.
- Reset mid-DRAIN: assert rst_n=0 for 1 edge at act_power=2 → all reset values on that edge; the next accept starts from act_power=0.
